// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO serializer family.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  // Bit-counter width for a frame of 'width' data bits (never below 1).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage : piso_pkg

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter with load and bit valid/ready handshakes.
// Optional trailing even-parity bit per frame when PISO_PARITY_EN is defined.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             ser_ready,
  output logic             out,
  output logic             out_valid,
  output logic             last
);

  localparam int unsigned       CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WIDTH - 1);

  piso_state_t      r_state;
  piso_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
`ifdef PISO_PARITY_EN
  logic             r_par;
  logic             w_par_nxt;
`endif

  logic             w_head;
  logic [WIDTH-1:0] w_shift_adv;
  logic             w_final;
  logic             w_bit_hs;
  logic             w_load_hs;

  // Output end of the register and its one-position advance toward it.
  assign w_head      = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign w_shift_adv = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                 : {1'b0, r_shift[WIDTH-1:1]};

  // State, shift register, counter (and parity) registers.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef PISO_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  // Output decode, handshakes and next-state logic.
  always_comb begin
    out         = 1'b0;
    out_valid   = 1'b0;
    last        = 1'b0;
    w_final     = 1'b0;
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
`ifdef PISO_PARITY_EN
    w_par_nxt   = r_par;
`endif

    case (r_state)
      SHIFT: begin
        out_valid = 1'b1;
        out       = w_head;
`ifndef PISO_PARITY_EN
        if (r_cnt == '0) begin
          last    = 1'b1;
          w_final = 1'b1;
        end
`endif
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        out_valid = 1'b1;
        out       = r_par;
        last      = 1'b1;
        w_final   = 1'b1;
      end
`endif
      default: ;
    endcase

    load_ready = (r_state == IDLE) || (w_final && ser_ready);
    w_bit_hs   = out_valid && ser_ready;
    w_load_hs  = load_valid && load_ready;

    if (w_load_hs) begin
      // A load on the final bit doubles as that bit's handshake.
      w_state_nxt = SHIFT;
      w_shift_nxt = din;
      w_cnt_nxt   = CNT_LOAD;
`ifdef PISO_PARITY_EN
      w_par_nxt   = ^din;
`endif
    end else if (w_bit_hs) begin
      case (r_state)
        SHIFT: begin
          w_shift_nxt = w_shift_adv;
          if (r_cnt == '0) begin
`ifdef PISO_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = IDLE;
            w_shift_nxt = '0;
`endif
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          w_state_nxt = IDLE;
          w_shift_nxt = '0;
        end
`endif
        default: w_state_nxt = IDLE;
      endcase
    end
  end

endmodule : piso_serializer
